// File: rtl/reg_wb_queue_if.sv
// Request/write-port bundle for reg_wb_queue: two producer request ports,
// the regfile write port, and the occupancy/pending status outputs.
// Modports: slave = the queue itself, master = whoever drives the requests and stall.
interface reg_wb_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** ADDR_W;

  // Port A: ALU/load path (priority producer)
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  // Port B: multi-cycle mult/div path
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  // Regfile write port
  logic              w_stall;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  // Status
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  w_stall,
    output a_ready, b_ready,
    output w_en, w_addr, w_data,
    output pending, count, full, empty
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output w_stall,
    input  a_ready, b_ready,
    input  w_en, w_addr, w_data,
    input  pending, count, full, empty
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back queue: merges port A/B register writes in arrival order onto the single regfile write port.
// Latency: 1 cycle from accept to w_en when empty (0 cycles with WB_BYPASS_EN defined).
// Backpressure: a_ready=!full, b_ready=!full&&!a_valid; w_stall holds the head in place.
// Ports: clk, reset (async active-high), bus (reg_wb_queue_if.slave: a_*, b_*, w_stall, w_*,
//   pending, count, full, empty).
// Optional build macro: WB_BYPASS_EN -- a write accepted into an empty, unstalled queue is driven
//   on w_* combinationally in the same cycle instead of being enqueued.
module reg_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  reg_wb_queue_if.slave       bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2 ** ADDR_W;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              full, empty;
  logic              a_fire, b_fire;
  logic              req_live;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              push, pop, bypass;
  logic [NREG-1:0]   pending_v;
  logic [PTR_W-1:0]  offset;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    a_fire   = 1'b0;
    b_fire   = 1'b0;
    req_addr = bus.a_addr;
    req_data = bus.a_data;
    req_live = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;
    push     = 1'b0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;

    // A always wins; B is only offered a slot when A is idle.
    a_fire = bus.a_valid && !full;
    b_fire = bus.b_valid && !full && !bus.a_valid;
    if (!a_fire) begin
      req_addr = bus.b_addr;
      req_data = bus.b_data;
    end
    // Writes to $zero complete the handshake but are discarded here.
    req_live = (a_fire || b_fire) && (req_addr != '0);

    pop = !empty && !bus.w_stall;
`ifdef WB_BYPASS_EN
    bypass = empty && !bus.w_stall && req_live;
`endif
    push = req_live && !bypass;

    if (push) begin
      addr_d[tail_q] = req_addr;
      data_d[tail_q] = req_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry i is occupied when its distance from head (mod DEPTH) is below count.
  always_comb begin
    pending_v = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (CNT_W'(offset) < count_q) begin
        pending_v[addr_q[i]] = 1'b1;
      end
    end
    pending_v[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.a_ready = !full;
  assign bus.b_ready = !full && !bus.a_valid;
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.pending = pending_v;

`ifdef WB_BYPASS_EN
  assign bus.w_en   = pop || bypass;
  assign bus.w_addr = bypass ? req_addr : addr_q[head_q];
  assign bus.w_data = bypass ? req_data : data_q[head_q];
`else
  // Registered head only: no combinational path from the request ports to w_*.
  assign bus.w_en   = pop;
  assign bus.w_addr = addr_q[head_q];
  assign bus.w_data = data_q[head_q];
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, latency, arbitration, $zero drop, full/drain, same-register ordering.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next rising edge.
// Expectations depend on whether WB_BYPASS_EN is defined for the build.
module tb_reg_wb_queue;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  reg_wb_queue_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

  reg_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset       = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
    bus.w_stall = 1'b0;
    #2;
    check("rst_count",   bus.count,   0);
    check("rst_empty",   bus.empty,   1);
    check("rst_full",    bus.full,    0);
    check("rst_w_en",    bus.w_en,    0);
    check("rst_pending", bus.pending, 0);
    tick();
    reset = 1'b0;

    // 1: three stalled entries, then an asynchronous reset mid-cycle
    bus.w_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.a_valid = 1'b1;
      bus.a_addr  = 5'(i);
      bus.a_data  = 32'(i);
      tick();
    end
    bus.a_valid = 1'b0;
    #1;
    check("t1_count",   bus.count,   3);
    check("t1_pending", bus.pending, 32'h0000_000E);
    bus.w_stall = 1'b0;
    #1;
    check("t1_w_en_pre",   bus.w_en,   1);
    check("t1_w_addr_pre", bus.w_addr, 1);
    reset = 1'b1;
    #1;
    check("t1_w_en_rst",    bus.w_en,    0);
    check("t1_count_rst",   bus.count,   0);
    check("t1_pending_rst", bus.pending, 0);
    check("t1_empty_rst",   bus.empty,   1);
    #1;
    reset = 1'b0;
    tick();

    // 2: single write latency
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd5;
    bus.a_data  = 32'hDEAD_BEEF;
    #1;
    check("t2_a_ready", bus.a_ready, 1);
`ifdef WB_BYPASS_EN
    check("t2_w_en_c0",   bus.w_en,   1);
    check("t2_w_addr_c0", bus.w_addr, 5);
    check("t2_w_data_c0", bus.w_data, 32'hDEAD_BEEF);
`else
    check("t2_w_en_c0", bus.w_en, 0);
`endif
    tick();
    bus.a_valid = 1'b0;
    #1;
`ifdef WB_BYPASS_EN
    check("t2_w_en_c1",    bus.w_en,    0);
    check("t2_pending_c1", bus.pending, 0);
`else
    check("t2_w_en_c1",    bus.w_en,    1);
    check("t2_w_addr_c1",  bus.w_addr,  5);
    check("t2_w_data_c1",  bus.w_data,  32'hDEAD_BEEF);
    check("t2_pending_c1", bus.pending, 32'h0000_0020);
`endif
    tick();
    check("t2_pending_c2", bus.pending, 0);
    check("t2_w_en_c2",    bus.w_en,    0);
    check("t2_empty_c2",   bus.empty,   1);

    // 3: A and B together, A has priority
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd3;
    bus.a_data  = 32'h11;
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd4;
    bus.b_data  = 32'h22;
    #1;
    check("t3_a_ready", bus.a_ready, 1);
    check("t3_b_ready", bus.b_ready, 0);
`ifdef WB_BYPASS_EN
    check("t3_w_en_c0",   bus.w_en,   1);
    check("t3_w_addr_c0", bus.w_addr, 3);
    check("t3_w_data_c0", bus.w_data, 32'h11);
`else
    check("t3_w_en_c0", bus.w_en, 0);
`endif
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("t3_b_ready_c1", bus.b_ready, 1);
    check("t3_w_en_c1",    bus.w_en,    1);
`ifdef WB_BYPASS_EN
    check("t3_w_addr_c1", bus.w_addr, 4);
    check("t3_w_data_c1", bus.w_data, 32'h22);
`else
    check("t3_w_addr_c1", bus.w_addr, 3);
    check("t3_w_data_c1", bus.w_data, 32'h11);
    check("t3_count_c1",  bus.count,  1);
`endif
    tick();
    bus.b_valid = 1'b0;
`ifndef WB_BYPASS_EN
    #1;
    check("t3_w_en_c2",   bus.w_en,   1);
    check("t3_w_addr_c2", bus.w_addr, 4);
    check("t3_w_data_c2", bus.w_data, 32'h22);
    check("t3_count_c2",  bus.count,  1);
    tick();
`endif
    check("t3_empty_end", bus.empty, 1);
    check("t3_w_en_end",  bus.w_en,  0);

    // 4: write to $zero is accepted and dropped
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd0;
    bus.a_data  = 32'hFFFF_FFFF;
    #1;
    check("t4_a_ready", bus.a_ready, 1);
    check("t4_w_en_c0", bus.w_en,    0);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("t4_count",   bus.count,   0);
    check("t4_w_en_c1", bus.w_en,    0);
    check("t4_pending", bus.pending, 0);
    tick();
    check("t4_w_en_c2", bus.w_en, 0);

    // 5: fill under stall, refuse a fifth push, then drain
    bus.w_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.a_valid = 1'b1;
      bus.a_addr  = 5'(i);
      bus.a_data  = 32'h100 + 32'(i);
      tick();
    end
    bus.a_addr = 5'd9;
    bus.a_data = 32'h999;
    #1;
    check("t5_full",    bus.full,    1);
    check("t5_a_ready", bus.a_ready, 0);
    check("t5_pending", bus.pending, 32'h0000_001E);
    check("t5_count",   bus.count,   4);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("t5_count_held",   bus.count,   4);
    check("t5_pending_held", bus.pending, 32'h0000_001E);
    bus.w_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t5_drain_w_en",    bus.w_en,    1);
      check("t5_drain_w_addr",  bus.w_addr,  64'(i));
      check("t5_drain_w_data",  bus.w_data,  64'(32'h100 + 32'(i)));
      check("t5_drain_pending", bus.pending, 64'(32'h1E & ~((32'h1 << i) - 32'h1)));
      tick();
    end
    check("t5_empty", bus.empty, 1);
    check("t5_w_en",  bus.w_en,  0);

    // 6: two writes to reg 7, last wins, pending held until both pop
    bus.w_stall = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd7;
    bus.a_data  = 32'h1;
    tick();
    bus.a_data  = 32'h2;
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("t6_pending", bus.pending, 32'h0000_0080);
    check("t6_count",   bus.count,   2);
    bus.w_stall = 1'b0;
    #1;
    check("t6_w_en_1",   bus.w_en,   1);
    check("t6_w_addr_1", bus.w_addr, 7);
    check("t6_w_data_1", bus.w_data, 1);
    tick();
    #1;
    check("t6_pending_2", bus.pending, 32'h0000_0080);
    check("t6_w_en_2",    bus.w_en,    1);
    check("t6_w_data_2",  bus.w_data,  2);
    tick();
    #1;
    check("t6_pending_3", bus.pending, 0);
    check("t6_empty",     bus.empty,   1);
    check("t6_w_en_3",    bus.w_en,    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
